// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting between the program counter
// and the IF/ID pipeline register. It issues req/ack transactions to
// instruction memory, captures returned instructions, tells the PC when to
// hold, and recovers cleanly from branch flushes that hit an in-flight request.
module fetch_stage #(
  parameter int WORDSIZE = 64,
  parameter int INSTSIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORDSIZE-1:0] i_pc,
  input  logic                i_branch,
  input  logic                i_id_stall,
  output logic                o_fetch_stall,
  output logic                o_imem_req,
  output logic [WORDSIZE-1:0] o_imem_addr,
  input  logic                i_imem_ack,
  input  logic [INSTSIZE-1:0] i_imem_rdata,
  output logic                o_ifid_valid,
  output logic [WORDSIZE-1:0] o_ifid_pc,
  output logic [INSTSIZE-1:0] o_ifid_instr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  logic [WORDSIZE-1:0] r_addr_q;     // address of the request currently on the bus
  logic [WORDSIZE-1:0] r_buf_pc;     // instruction parked while decode is stalled
  logic [INSTSIZE-1:0] r_buf_instr;
  logic                r_ifid_valid;
  logic [WORDSIZE-1:0] r_ifid_pc;
  logic [INSTSIZE-1:0] r_ifid_instr;

  logic                w_take;       // a live (non-flushed) request completes this cycle
  logic                w_hold_release;

  // Request / address / PC-hold decode from the registered state.
  always_comb begin
    w_take         = (r_state == S_REQ) && i_imem_ack;
    w_hold_release = (r_state == S_HOLD) && !i_id_stall;
    o_imem_req     = (r_state == S_REQ) || (r_state == S_DRAIN);
    // A draining request must keep the abandoned address on the bus even
    // though the PC has already moved to the branch target.
    o_imem_addr    = (r_state == S_DRAIN) ? r_addr_q : i_pc;
    o_fetch_stall  = !(i_branch || (w_take && !i_id_stall) || w_hold_release);
  end

  assign o_ifid_valid = r_ifid_valid;
  assign o_ifid_pc    = r_ifid_pc;
  assign o_ifid_instr = r_ifid_instr;

  // Fetch FSM plus IF/ID register and hold buffer; branch always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr_q     <= '0;
      r_buf_pc     <= '0;
      r_buf_instr  <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (i_branch) r_ifid_valid <= 1'b0;
        end
        S_REQ: begin
          r_addr_q <= i_pc;
          if (i_branch) begin
            r_ifid_valid <= 1'b0;
            // An unanswered request cannot be withdrawn, so wait it out.
            r_state      <= i_imem_ack ? S_REQ : S_DRAIN;
          end else if (i_imem_ack) begin
            if (!i_id_stall) begin
              r_ifid_valid <= 1'b1;
              r_ifid_pc    <= i_pc;
              r_ifid_instr <= i_imem_rdata;
            end else begin
              r_buf_pc    <= i_pc;
              r_buf_instr <= i_imem_rdata;
              r_state     <= S_HOLD;
            end
          end else if (!i_id_stall) begin
            r_ifid_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (i_imem_ack) r_state <= S_REQ;
          if (i_branch || !i_id_stall) r_ifid_valid <= 1'b0;
        end
        S_HOLD: begin
          if (i_branch) begin
            r_ifid_valid <= 1'b0;
            r_state      <= S_REQ;
          end else if (!i_id_stall) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_buf_pc;
            r_ifid_instr <= r_buf_instr;
            r_state      <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table for the documented fetch scenarios,
// a hand-written asynchronous reset during a drain, then a long randomized
// run checked against a transaction-level model of the fetch stage and PC.
module tb_fetch_stage;
  localparam int W = 64;
  localparam int I = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pc;
  logic         branch;
  logic         id_stall;
  logic         ack;
  logic [I-1:0] rdata;
  logic         fetch_stall;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         ifid_valid;
  logic [W-1:0] ifid_pc;
  logic [I-1:0] ifid_instr;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.WORDSIZE(W), .INSTSIZE(I)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pc         (pc),
    .i_branch     (branch),
    .i_id_stall   (id_stall),
    .o_fetch_stall(fetch_stall),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (ack),
    .i_imem_rdata (rdata),
    .o_ifid_valid (ifid_valid),
    .o_ifid_pc    (ifid_pc),
    .o_ifid_instr (ifid_instr)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [I-1:0] mem(input logic [W-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic br;
    int   tgt;
    logic st;
    logic ack;
    logic e_req;
    int   e_addr;
    logic e_stall;
    logic e_valid;
    int   e_ifpc;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic br, input int tgt, input logic st, input logic ak,
                      input logic e_req, input int e_addr, input logic e_stall,
                      input logic e_valid, input int e_ifpc);
    vq.push_back('{br, tgt, st, ak, e_req, e_addr, e_stall, e_valid, e_ifpc});
  endtask

  // Holds reset for two cycles, checks the reset state, releases on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; branch = 1'b0; id_stall = 1'b0; ack = 1'b0; pc = '0; rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req",   64'(imem_req), 64'd0);
    chk("rst_valid", 64'(ifid_valid), 64'd0);
    chk("rst_ifpc",  ifid_pc, 64'd0);
    chk("rst_instr", 64'(ifid_instr), 64'd0);
    rst = 1'b0;
  endtask

  // Transaction-level model state for the random phase.
  bit           m_started;
  logic [W-1:0] drain_q[$];
  logic [W-1:0] held_pc[$];
  logic [I-1:0] held_in[$];
  logic         m_valid;
  logic [W-1:0] m_pc;
  logic [I-1:0] m_instr;
  logic [W-1:0] m_pcreg;

  initial begin
    logic [W-1:0] tgt;
    logic         in_drain, in_hold, e_req, e_take, e_stall;
    logic [W-1:0] e_addr;

    // Directed scenarios, one row per cycle starting at the first cycle after reset.
    //    br tgt    st ack  req addr   stall valid ifpc
    addv(0, 0,     0, 1,   0, 0,     1,    0,    0);      // idle cycle after reset
    addv(0, 0,     0, 1,   1, 0,     0,    0,    0);
    addv(0, 0,     0, 1,   1, 4,     0,    1,    0);
    addv(0, 0,     0, 0,   1, 8,     1,    1,    4);      // ack delayed at pc=8
    addv(0, 0,     0, 0,   1, 8,     1,    0,    4);
    addv(0, 0,     0, 0,   1, 8,     1,    0,    4);
    addv(0, 0,     0, 1,   1, 8,     0,    0,    4);
    addv(0, 0,     0, 1,   1, 12,    0,    1,    8);
    addv(0, 0,     1, 1,   1, 16,    1,    1,    12);     // ack under decode stall
    addv(0, 0,     1, 0,   0, 0,     1,    1,    12);     // HOLD
    addv(0, 0,     0, 0,   0, 0,     0,    1,    12);     // HOLD release
    addv(0, 0,     0, 1,   1, 20,    0,    1,    16);
    addv(0, 0,     0, 1,   1, 24,    0,    1,    20);
    addv(0, 0,     0, 1,   1, 28,    0,    1,    24);
    addv(0, 0,     0, 0,   1, 32,    1,    1,    28);
    addv(1, 'h100, 0, 0,   1, 32,    0,    0,    28);     // branch with 0x20 outstanding
    addv(0, 0,     0, 0,   1, 32,    1,    0,    28);     // DRAIN
    addv(0, 0,     0, 1,   1, 32,    1,    0,    28);     // late ack dropped
    addv(0, 0,     0, 1,   1, 'h100, 0,    0,    28);
    addv(0, 0,     0, 1,   1, 'h104, 0,    1,    'h100);
    addv(1, 'h200, 1, 1,   1, 'h108, 0,    1,    'h104);  // branch+ack+id_stall
    addv(0, 0,     0, 1,   1, 'h200, 0,    0,    'h104);
    addv(0, 0,     0, 0,   1, 'h204, 1,    1,    'h200);
    addv(1, 'h300, 0, 0,   1, 'h204, 0,    0,    'h200);
    addv(0, 0,     0, 0,   1, 'h204, 1,    0,    'h200);  // still draining

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      branch   = vq[i].br;
      id_stall = vq[i].st;
      ack      = vq[i].ack;
      rdata    = mem(64'(vq[i].e_addr));
      #1;
      chk($sformatf("v%0d_req", i), 64'(imem_req), 64'(vq[i].e_req));
      if (vq[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, 64'(vq[i].e_addr));
      chk($sformatf("v%0d_stall", i), 64'(fetch_stall), 64'(vq[i].e_stall));
      chk($sformatf("v%0d_valid", i), 64'(ifid_valid), 64'(vq[i].e_valid));
      chk($sformatf("v%0d_ifpc", i), ifid_pc, 64'(vq[i].e_ifpc));
      if (vq[i].e_valid) chk($sformatf("v%0d_instr", i), 64'(ifid_instr), 64'(mem(64'(vq[i].e_ifpc))));
      $display("vec %0d: pc=%0h req=%0b addr=%0h stall=%0b ifid_valid=%0b ifid_pc=%0h",
               i, pc, imem_req, imem_addr, fetch_stall, ifid_valid, ifid_pc);
      @(negedge clk);
      if (vq[i].br) pc = 64'(vq[i].tgt);
      else if (!vq[i].e_stall) pc = pc + 64'd4;
    end

    // Asynchronous reset while a flushed request is still draining.
    ack = 1'b0; branch = 1'b0; id_stall = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("drain_rst_req",   64'(imem_req), 64'd0);
    chk("drain_rst_valid", 64'(ifid_valid), 64'd0);
    chk("drain_rst_ifpc",  ifid_pc, 64'd0);
    @(negedge clk);
    rst = 1'b0; pc = '0; ack = 1'b1; rdata = mem(64'd0);
    #1 chk("post_rst_idle_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    #1;
    chk("post_rst_req",  64'(imem_req), 64'd1);
    chk("post_rst_addr", imem_addr, 64'd0);
    @(negedge clk);
    pc = 64'd4; rdata = mem(64'd4);
    #1;
    chk("post_rst_valid", 64'(ifid_valid), 64'd1);
    chk("post_rst_ifpc",  ifid_pc, 64'd0);
    chk("post_rst_instr", 64'(ifid_instr), 64'(mem(64'd0)));
    $display("reset during drain: req=%0b ifid_pc=%0h", imem_req, ifid_pc);

    // Randomized run against the reference model.
    do_reset();
    m_started = 1'b0; m_valid = 1'b0; m_pc = '0; m_instr = '0; m_pcreg = '0;
    drain_q.delete(); held_pc.delete(); held_in.delete();
    for (int n = 0; n < 3000; n++) begin
      branch   = ($urandom_range(0, 9) == 0);
      tgt      = 64'($urandom_range(0, 1023)) << 2;
      id_stall = ($urandom_range(0, 3) == 0);
      ack      = ($urandom_range(0, 2) != 0);
      in_drain = (drain_q.size() != 0);
      in_hold  = (held_pc.size() != 0);
      e_req    = m_started && !in_hold;
      e_addr   = in_drain ? drain_q[0] : m_pcreg;
      e_take   = e_req && !in_drain && ack;
      e_stall  = !(branch || (e_take && !id_stall) || (in_hold && !id_stall));
      pc       = m_pcreg;
      rdata    = mem(e_addr);
      #1;
      chk("rnd_req", 64'(imem_req), 64'(e_req));
      if (e_req) chk("rnd_addr", imem_addr, e_addr);
      chk("rnd_stall", 64'(fetch_stall), 64'(e_stall));
      chk("rnd_valid", 64'(ifid_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_ifpc",  ifid_pc, m_pc);
        chk("rnd_instr", 64'(ifid_instr), 64'(m_instr));
      end
      @(negedge clk);
      // Model update for the edge just taken.
      if (!m_started) begin
        m_started = 1'b1;
        if (branch) m_valid = 1'b0;
      end else if (branch) begin
        m_valid = 1'b0;
        held_pc.delete(); held_in.delete();
        if (in_drain) begin
          if (ack) drain_q.delete();
        end else if (e_req && !ack) begin
          drain_q.push_back(e_addr);
        end
      end else if (in_hold) begin
        if (!id_stall) begin
          m_valid = 1'b1; m_pc = held_pc.pop_front(); m_instr = held_in.pop_front();
          $display("xfer: pc=%0h instr=%0h (from hold)", m_pc, m_instr);
        end
      end else if (in_drain) begin
        if (ack) drain_q.delete();
        if (!id_stall) m_valid = 1'b0;
      end else if (ack) begin
        if (!id_stall) begin
          m_valid = 1'b1; m_pc = e_addr; m_instr = mem(e_addr);
          $display("xfer: pc=%0h instr=%0h", m_pc, m_instr);
        end else begin
          held_pc.push_back(e_addr); held_in.push_back(mem(e_addr));
        end
      end else if (!id_stall) begin
        m_valid = 1'b0;
      end
      if (branch) m_pcreg = tgt;
      else if (!e_stall) m_pcreg = m_pcreg + 64'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Presents the current pc to instruction memory over a req/ack handshake and captures the returned instruction into the IF/ID pipeline register.
- Drives the PC's stall input so the PC advances only when an instruction is accepted or a branch redirects fetch.
- Handles decode back-pressure (id_stall) and branch flushes, including flushes that arrive while a memory request is still outstanding.

Parameters:
- WORDSIZE, 64, width of pc and instruction addresses.
- INSTSIZE, 32, width of an instruction word.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  WORDSIZE  current PC value from the program counter.
- branch  in  1  branch taken; same signal that drives the PC's branch input; flushes fetch.
- id_stall  in  1  decode cannot accept a new instruction this cycle.
- fetch_stall  out  1  to the PC stall input; high means hold pc.
- imem_req  out  1  instruction-memory request valid.
- imem_addr  out  WORDSIZE  request address; stable while imem_req is high and ack is not yet seen.
- imem_ack  in  1  memory completes the request this cycle; imem_rdata is valid in the same cycle.
- imem_rdata  in  INSTSIZE  instruction data.
- ifid_valid  out  1  IF/ID register holds a valid instruction.
- ifid_pc  out  WORDSIZE  address of the instruction in IF/ID.
- ifid_instr  out  INSTSIZE  instruction in IF/ID.

Behaviour:
- Reset (async, any time, including with a request outstanding):
  - state=IDLE; ifid_valid=0; ifid_pc=0; ifid_instr=0; hold buffer=0; addr_q=0.
  - imem_req=0 while rst is high.
- States:
  - IDLE: no request; next state is REQ unconditionally.
  - REQ: imem_req=1; imem_addr=pc combinationally; addr_q<=pc every cycle.
  - DRAIN: a flush is pending on an outstanding request; imem_req=1; imem_addr=addr_q.
  - HOLD: data received while decode is stalled; imem_req=0; instruction and address held in a buffer.
- Handshake:
  - Once imem_req is high, it and imem_addr stay constant until a cycle with imem_ack=1.
  - A transfer completes on the edge where imem_req & imem_ack.
  - Single-cycle turnaround: the next request may be presented in the following cycle.
- fetch_stall:
  - Equals 0 if branch=1.
  - Else 0 if (REQ & imem_ack & !id_stall).
  - Else 0 if (HOLD & !id_stall).
  - Else 1. IDLE and DRAIN stall unless branch is high.
- Transitions, branch has highest priority:
  - Any state, branch=1: ifid_valid<=0.
    - From REQ with no ack, go to DRAIN (addr_q keeps the old address).
    - From REQ with ack, the data is discarded and the state is REQ.
    - From DRAIN with no ack, stay in DRAIN.
    - From DRAIN with ack, the data is discarded and the state is REQ.
    - From HOLD, the buffer is discarded and the state is REQ.
    - From IDLE, go to REQ.
  - REQ, ack, !id_stall: ifid_valid<=1, ifid_pc<=imem_addr, ifid_instr<=imem_rdata; stay REQ. Zero-bubble: the next pc is presented the following cycle.
  - REQ, ack, id_stall: buffer<=(imem_addr, imem_rdata); go to HOLD; the IF/ID register is held.
  - REQ, no ack, !id_stall: ifid_valid<=0 (bubble to decode).
  - REQ, no ack, id_stall: IF/ID is held.
  - DRAIN, ack, no branch: data is dropped; go to REQ. IF/ID is held if id_stall, else ifid_valid<=0.
  - HOLD, !id_stall: IF/ID<=buffer, ifid_valid<=1; go to REQ.
  - HOLD, id_stall: all state is held.
- Throughput: one instruction per cycle when memory acks in the same cycle as the request and decode never stalls.
- No instruction is ever duplicated or lost. Every accepted instruction appears in IF/ID exactly once, with the pc it was fetched from.

Test Plan:
- Reset, then imem_ack tied to 1, id_stall=0, PC incrementing by 4: ifid_pc is 0,4,8,12 on consecutive cycles; ifid_valid=1 from the second cycle after reset; fetch_stall=0 throughout.
- imem_ack delayed 3 cycles on the request at pc=8: imem_addr is held at 8 for all 3 wait cycles; fetch_stall=1; ifid_valid=0 bubbles; IF/ID gets pc=8 on ack.
- id_stall=1 for 2 cycles while the request at pc=16 acks: state goes to HOLD; imem_req=0; IF/ID keeps pc=12; on id_stall release, IF/ID gets pc=16 and the next request addr is 20.
- branch=1 with branchpc=0x100 while the request at 0x20 is outstanding: state goes to DRAIN with imem_addr still 0x20; the late ack data is dropped; the next request addr is 0x100; ifid_valid=0 until 0x100 is fetched.
- branch and imem_ack in the same cycle, with id_stall=1 simultaneously: fetched data is discarded; ifid_valid=0; fetch_stall=0; next addr is branchpc.
- rst asserted mid-DRAIN: imem_req drops immediately; ifid_valid=0; after release, the first request is pc=0.
